// File: rtl/config_menu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : config_menu_ctrl
//  Description : Configuration menu sequencer. Owns the menu cursor, holds
//                twelve option values, turns button pulses into cursor moves
//                and value edits, and keeps the on-screen option digits
//                current through the text buffer write port.
//  Revision    : 1.0  initial release
// ============================================================================
module config_menu_ctrl #(
  parameter int unsigned NUM_OPTS      = 12,
  parameter int unsigned OPT_MAX       = 9,
  parameter logic [7:0]  DIGIT_BASE    = 8'h30,
  parameter int unsigned LEFT_VAL_COL  = 18,
  parameter int unsigned RIGHT_VAL_COL = 38
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        btn_up_in,
  input  logic        btn_down_in,
  input  logic        btn_left_in,
  input  logic        btn_right_in,
  input  logic        btn_start_in,
  output logic [3:0]  ptr_index_out,
  output logic [47:0] opt_values_out,
  output logic [9:0]  buf_write_addr_out,
  output logic [7:0]  buf_write_data_out,
  output logic        buf_write_en_out,
  output logic        config_done_out
);

  localparam logic [3:0] c_last_idx  = 4'(NUM_OPTS - 1);
  localparam logic [3:0] c_opt_max   = 4'(OPT_MAX);
  localparam logic [9:0] c_left_col  = 10'(LEFT_VAL_COL);
  localparam logic [9:0] c_right_col = 10'(RIGHT_VAL_COL);

  // WRITE is the cycle in which the button-driven buffer write is visible.
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_init_cnt, w_init_cnt_nxt;
  logic [3:0]  r_ptr, w_ptr_nxt;
  logic [47:0] r_vals, w_vals_nxt;
  logic [9:0]  r_addr, w_addr_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_we, w_we_nxt;
  logic        r_done, w_done_nxt;
  logic [3:0]  w_sel_val;
  logic [3:0]  w_init_val;

  // Buffer address of an option's digit: row*40 + col, built from shifts.
  function automatic logic [9:0] slot_addr(input logic [3:0] idx);
    logic [9:0] row;
    logic [9:0] col;
    if (idx < 4'd8) begin
      row = 10'd3 + {5'd0, idx, 1'b0};
      col = c_left_col;
    end else begin
      row = 10'd3 + {5'd0, idx - 4'd8, 1'b0};
      col = c_right_col;
    end
    return (row << 5) + (row << 3) + col;
  endfunction

  assign w_sel_val  = r_vals[{r_ptr, 2'b00} +: 4];
  assign w_init_val = r_vals[{r_init_cnt, 2'b00} +: 4];

  // State and all output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= S_INIT;
      r_init_cnt <= 4'd0;
      r_ptr      <= 4'd0;
      r_vals     <= 48'd0;
      r_addr     <= 10'd0;
      r_data     <= 8'd0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_vals     <= w_vals_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_we       <= w_we_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; address/data hold unless written.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_ptr_nxt      = r_ptr;
    w_vals_nxt     = r_vals;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_we_nxt       = 1'b0;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_INIT: begin
        // Paint every option digit once, buttons dropped.
        w_we_nxt   = 1'b1;
        w_addr_nxt = slot_addr(r_init_cnt);
        w_data_nxt = DIGIT_BASE + {4'd0, w_init_val};
        if (r_init_cnt == c_last_idx) begin
          w_init_cnt_nxt = 4'd0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 4'd1;
        end
      end
      S_IDLE: begin
        // Fixed priority: start > up > down > right > left.
        if (btn_start_in) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (btn_up_in) begin
          w_ptr_nxt = (r_ptr == 4'd0) ? c_last_idx : r_ptr - 4'd1;
        end else if (btn_down_in) begin
          w_ptr_nxt = (r_ptr == c_last_idx) ? 4'd0 : r_ptr + 4'd1;
        end else if (btn_right_in) begin
          if (w_sel_val < c_opt_max) begin
            w_vals_nxt[{r_ptr, 2'b00} +: 4] = w_sel_val + 4'd1;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = slot_addr(r_ptr);
            w_data_nxt  = DIGIT_BASE + {4'd0, w_sel_val + 4'd1};
            w_state_nxt = S_WRITE;
          end
        end else if (btn_left_in) begin
          if (w_sel_val != 4'd0) begin
            w_vals_nxt[{r_ptr, 2'b00} +: 4] = w_sel_val - 4'd1;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = slot_addr(r_ptr);
            w_data_nxt  = DIGIT_BASE + {4'd0, w_sel_val - 4'd1};
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // The write strobe is visible now; buttons are dropped.
        w_state_nxt = S_IDLE;
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign ptr_index_out      = r_ptr;
  assign opt_values_out     = r_vals;
  assign buf_write_addr_out = r_addr;
  assign buf_write_data_out = r_data;
  assign buf_write_en_out   = r_we;
  assign config_done_out    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_config_menu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_config_menu_ctrl
//  Description : Self-checking bench for config_menu_ctrl with a behavioural
//                menu model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_config_menu_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        btn_up_in, btn_down_in, btn_left_in, btn_right_in, btn_start_in;
  logic [3:0]  ptr_index_out;
  logic [47:0] opt_values_out;
  logic [9:0]  buf_write_addr_out;
  logic [7:0]  buf_write_data_out;
  logic        buf_write_en_out;
  logic        config_done_out;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the menu
  int m_val[12];
  int m_ptr;
  int m_init_k;
  bit m_finished;
  bit m_btn_write;
  bit m_we;
  bit m_done;
  int m_addr;
  int m_data;

  int exp_init_addr[12] = '{138, 218, 298, 378, 458, 538, 618, 698, 158, 238, 318, 398};

  config_menu_ctrl dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .btn_up_in          (btn_up_in),
    .btn_down_in        (btn_down_in),
    .btn_left_in        (btn_left_in),
    .btn_right_in       (btn_right_in),
    .btn_start_in       (btn_start_in),
    .ptr_index_out      (ptr_index_out),
    .opt_values_out     (opt_values_out),
    .buf_write_addr_out (buf_write_addr_out),
    .buf_write_data_out (buf_write_data_out),
    .buf_write_en_out   (buf_write_en_out),
    .config_done_out    (config_done_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic int slot(input int i);
    int row;
    int col;
    row = 3 + 2 * (i % 8);
    col = (i < 8) ? 18 : 38;
    return row * 40 + col;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_val[i]) m_val[i] = 0;
    m_ptr = 0; m_init_k = 0; m_finished = 0; m_btn_write = 0;
    m_we = 0; m_done = 0; m_addr = 0; m_data = 0;
  endtask

  // One clock edge of the menu as described by its rules; b = {start,up,down,right,left}
  task automatic model_edge(input logic [4:0] b);
    m_done = 0;
    m_we = 0;
    if (m_init_k < 12) begin
      m_we = 1; m_addr = slot(m_init_k); m_data = 48 + m_val[m_init_k];
      m_init_k++;
    end else if (m_finished || m_btn_write) begin
      m_btn_write = 0;
    end else if (b[4]) begin
      m_done = 1; m_finished = 1;
    end else if (b[3]) begin
      m_ptr = (m_ptr + 11) % 12;
    end else if (b[2]) begin
      m_ptr = (m_ptr + 1) % 12;
    end else if (b[1] && m_val[m_ptr] < 9) begin
      m_val[m_ptr]++;
      m_we = 1; m_addr = slot(m_ptr); m_data = 48 + m_val[m_ptr]; m_btn_write = 1;
    end else if (!b[1] && b[0] && m_val[m_ptr] > 0) begin
      m_val[m_ptr]--;
      m_we = 1; m_addr = slot(m_ptr); m_data = 48 + m_val[m_ptr]; m_btn_write = 1;
    end
  endtask

  task automatic compare_all();
    logic [47:0] packed_vals;
    packed_vals = '0;
    for (int i = 0; i < 12; i++) packed_vals[4*i +: 4] = 4'(m_val[i]);
    chk("ptr",  48'(ptr_index_out),      48'(m_ptr));
    chk("vals", opt_values_out,          packed_vals);
    chk("we",   48'(buf_write_en_out),   48'(m_we));
    chk("addr", 48'(buf_write_addr_out), 48'(m_addr));
    chk("data", 48'(buf_write_data_out), 48'(m_data));
    chk("done", 48'(config_done_out),    48'(m_done));
  endtask

  // Apply buttons for one cycle, step the model, compare after the edge.
  task automatic tick(input logic [4:0] b);
    {btn_start_in, btn_up_in, btn_down_in, btn_right_in, btn_left_in} = b;
    @(posedge clk_in);
    #1;
    model_edge(b);
    compare_all();
    {btn_start_in, btn_up_in, btn_down_in, btn_right_in, btn_left_in} = 5'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ptr"},  48'(ptr_index_out),      48'd0);
    chk({tag, "_vals"}, opt_values_out,          48'd0);
    chk({tag, "_we"},   48'(buf_write_en_out),   48'd0);
    chk({tag, "_addr"}, 48'(buf_write_addr_out), 48'd0);
    chk({tag, "_data"}, 48'(buf_write_data_out), 48'd0);
    chk({tag, "_done"}, 48'(config_done_out),    48'd0);
  endtask

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_LEFT  = 5'b00001;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_START = 5'b10000;

  initial begin
    rst_n_in = 1'b0;
    {btn_start_in, btn_up_in, btn_down_in, btn_right_in, btn_left_in} = 5'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_zero("reset");

    // Release away from the edge; initial painting of all digits
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(B_RIGHT);  // dropped during painting
      chk("init_we",   48'(buf_write_en_out),   48'd1);
      chk("init_addr", 48'(buf_write_addr_out), 48'(exp_init_addr[k]));
      chk("init_data", 48'(buf_write_data_out), 48'h30);
    end
    tick(B_NONE);
    chk("init_end_we", 48'(buf_write_en_out), 48'd0);

    // Cursor wrap and moves
    tick(B_UP);    chk("up_wrap", 48'(ptr_index_out), 48'd11);
    tick(B_NONE);
    tick(B_DOWN);  chk("down_wrap", 48'(ptr_index_out), 48'd0);
    tick(B_NONE);
    tick(B_DOWN);  chk("down_1", 48'(ptr_index_out), 48'd1);
    tick(B_UP); tick(B_UP);
    chk("ptr_11", 48'(ptr_index_out), 48'd11);

    // Edit the last option
    tick(B_RIGHT);
    chk("edit_we",   48'(buf_write_en_out),   48'd1);
    chk("edit_addr", 48'(buf_write_addr_out), 48'd398);
    chk("edit_data", 48'(buf_write_data_out), 48'h31);
    chk("edit_val",  48'(opt_values_out[47:44]), 48'd1);
    tick(B_NONE);
    tick(B_DOWN);
    tick(B_LEFT);
    chk("left_floor_we", 48'(buf_write_en_out), 48'd0);

    // Saturation at the maximum
    for (int k = 0; k < 12; k++) begin
      tick(B_RIGHT);
      tick(B_NONE);
    end
    chk("sat_val", 48'(opt_values_out[3:0]), 48'd9);

    // Simultaneous up+right, then a right pulse during the write cycle
    tick(B_UP | B_RIGHT);
    chk("prio_we", 48'(buf_write_en_out), 48'd0);
    tick(B_RIGHT);
    tick(B_RIGHT);
    tick(B_NONE);
    chk("drop_val", 48'(opt_values_out[47:44]), 48'd2);

    // Randomized button traffic without start
    for (int n = 0; n < 400; n++) begin
      logic [4:0] b;
      b = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31)) & 5'b01111;
      tick(b);
    end

    // Finish configuration; everything frozen afterwards
    tick(B_NONE); tick(B_NONE);
    tick(B_START | B_RIGHT);
    chk("done_pulse", 48'(config_done_out), 48'd1);
    tick(B_NONE);
    chk("done_once", 48'(config_done_out), 48'd0);
    for (int n = 0; n < 20; n++) tick(5'($urandom_range(0, 31)));

    // Reset in the middle of painting
    rst_n_in = 1'b0;
    #1;
    check_zero("reset2");
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int k = 0; k < 6; k++) tick(B_NONE);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_zero("mid_init_reset");
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick(B_NONE);
    chk("restart_addr", 48'(buf_write_addr_out), 48'd138);
    for (int k = 0; k < 14; k++) tick(B_NONE);
    for (int n = 0; n < 100; n++) tick(5'($urandom_range(0, 31)) & 5'b01111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
